// File: rtl/toeplitz_pkg.sv
// Shared constants and types for the Toeplitz hashing blocks (gencol, toeplitz_mac).
package toeplitz_pkg;

  // Default matrix geometry shared with the column generators
  localparam int unsigned N_DEF      = 256;
  localparam int unsigned L_DEF      = 128;
  localparam int unsigned STRIDE_DEF = 1;
  localparam int unsigned BS_DEF     = 32;

  // Width of the beat counter
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  // True when the beat about to be accepted completes the block
  function automatic logic is_last_beat(input logic signed [CNT_W-1:0] cnt,
                                        input int stride,
                                        input int n);
    return (cnt + stride) == n;
  endfunction

endpackage

// File: rtl/toeplitz_mac_gf2_colsum.sv
// Masked GF(2) column sum: XOR of every column slice whose data bit is set.
module gf2_colsum #(
  parameter int unsigned STRIDE = 1,
  parameter int unsigned L      = 128
) (
  input  logic [STRIDE*L-1:0] cols,
  input  logic [STRIDE-1:0]   in_data,
  output logic [L-1:0]        contrib_c
);

  // Reduce the selected columns into one L-bit contribution
  always_comb begin
    contrib_c = '0;
    for (int k = 0; k < int'(STRIDE); k++) begin
      if (in_data[k]) begin
        contrib_c = contrib_c ^ cols[k*L +: L];
      end
    end
  end

endmodule

// File: rtl/toeplitz_mac.sv
// Toeplitz GF(2) matrix-vector multiplier: accumulates STRIDE columns per beat
// into an L-bit hash over an N-bit data block, and keeps the external column
// generators aligned by resetting them on every non-transfer cycle.
// Optional build macro TOEPLITZ_MAC_STATS_EN adds blk_cnt / abort_cnt outputs.
// N must be a multiple of STRIDE.
module toeplitz_mac
  import toeplitz_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned L      = L_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STRIDE*L-1:0] cols,
  output logic                gen_reset,
  input  logic [STRIDE-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [L-1:0]        hash,
  output logic                out_valid,
  input  logic                out_ready
`ifdef TOEPLITZ_MAC_STATS_EN
  ,
  output logic [31:0]         blk_cnt,
  output logic [31:0]         abort_cnt
`endif
);

  localparam int N_I      = int'(N);
  localparam int STRIDE_I = int'(STRIDE);

  mac_state_t              state, state_d;
  logic [L-1:0]            acc, acc_d;
  logic [L-1:0]            hash_d;
  logic                    out_valid_d;
  logic signed [CNT_W-1:0] cnt, cnt_d;
  logic [L-1:0]            contrib;
  logic                    accept;
  logic                    last_beat;

  gf2_colsum #(
    .STRIDE (STRIDE),
    .L      (L)
  ) u_colsum (
    .cols      (cols),
    .in_data   (in_data),
    .contrib_c (contrib)
  );

  // Handshake and generator realignment
  assign in_ready  = (state != DONE);
  assign accept    = in_valid && in_ready;
  assign gen_reset = reset || !accept;
  assign last_beat = is_last_beat(cnt, STRIDE_I, N_I);

  // Next-state and datapath update
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    cnt_d       = cnt;
    hash_d      = hash;
    out_valid_d = out_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          if (last_beat) begin
            hash_d      = contrib;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = DONE;
          end else begin
            acc_d   = contrib;
            cnt_d   = CNT_W'(STRIDE_I);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (last_beat) begin
            hash_d      = acc ^ contrib;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = DONE;
          end else begin
            acc_d = acc ^ contrib;
            cnt_d = cnt + CNT_W'(STRIDE_I);
          end
        end else begin
          // Gap mid-block: discard the partial sum, generators restart too
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      hash      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      hash      <= hash_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef TOEPLITZ_MAC_STATS_EN
  logic stat_last;
  logic stat_abort;

  assign stat_last  = accept && last_beat;
  assign stat_abort = (state == RUN) && !accept;

  // Completed-block and aborted-block event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      if (stat_last)  blk_cnt   <= blk_cnt + 32'd1;
      if (stat_abort) abort_cnt <= abort_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_toeplitz_mac.sv
// Testbench for toeplitz_mac with behavioural column generators (N=8, L=4).
// Runs the STRIDE=1 instance through directed, random, abort and reset
// scenarios, and a second STRIDE=2 instance through an all-ones block.
`timescale 1ns/1ps
module tb_toeplitz_mac;

  localparam int unsigned N = 8;
  localparam int unsigned L = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // STRIDE=1 instance
  logic [L-1:0] cols;
  logic         gen_reset;
  logic [0:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [L-1:0] hash;
  logic         out_valid;
  logic         out_ready = 1'b1;

  // STRIDE=2 instance
  logic [2*L-1:0] cols2;
  logic           gen_reset2;
  logic [1:0]     in_data2 = '0;
  logic           in_valid2 = 1'b0;
  logic           in_ready2;
  logic [L-1:0]   hash2;
  logic           out_valid2;
  logic           out_ready2 = 1'b1;

`ifdef TOEPLITZ_MAC_STATS_EN
  logic [31:0] blk_cnt, abort_cnt, blk_cnt2, abort_cnt2;
`endif

  // Generator matrix parameters (row0[0] is shadowed by col0[0])
  logic [7:0] row0 = '0;
  logic [3:0] col0 = '0;

  int gidx1 = 0;
  int gidx2 = 0;
  int n_vec = 0;
  int n_err = 0;
  int exp_blk = 0;
  int exp_abort = 0;
  logic [1:0] rdy_mode = 2'd0;

  logic [L-1:0] sb[$];
  logic [L-1:0] held;
  bit           held_vld = 0;

  always #5 clk = ~clk;

  toeplitz_mac #(.N(N), .L(L), .STRIDE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .gen_reset (gen_reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hash      (hash),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef TOEPLITZ_MAC_STATS_EN
    ,
    .blk_cnt   (blk_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  toeplitz_mac #(.N(N), .L(L), .STRIDE(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols2),
    .gen_reset (gen_reset2),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .hash      (hash2),
    .out_valid (out_valid2),
    .out_ready (out_ready2)
`ifdef TOEPLITZ_MAC_STATS_EN
    ,
    .blk_cnt   (blk_cnt2),
    .abort_cnt (abort_cnt2)
`endif
  );

  // Matrix column j: T[i][j] = col0[i-j] below/on diagonal, row0[j-i] above
  function automatic logic [L-1:0] colgen(input int j, input logic [7:0] r0, input logic [3:0] c0);
    logic [L-1:0] c;
    c = '0;
    for (int i = 0; i < int'(L); i++) begin
      if (j < 0 || j >= int'(N)) c[i] = 1'b0;
      else if (i >= j)           c[i] = c0[i-j];
      else                       c[i] = r0[j-i];
    end
    return c;
  endfunction

  // Reference hash as row-by-row parity: hash[i] = ^(row_i & d)
  function automatic logic [L-1:0] model_hash(input logic [7:0] d, input logic [7:0] r0, input logic [3:0] c0);
    logic [L-1:0] h;
    logic [7:0]   row;
    for (int i = 0; i < int'(L); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        row[j] = (i >= j) ? c0[i-j] : r0[j-i];
      end
      h[i] = ^(row & d);
    end
    return h;
  endfunction

  // Behavioural column generators: restart on gen_reset, else advance
  always @(posedge clk) begin
    if (gen_reset) gidx1 <= 0;
    else           gidx1 <= gidx1 + 1;
    if (gen_reset2) gidx2 <= 0;
    else            gidx2 <= gidx2 + 2;
  end

  assign cols  = colgen(gidx1, row0, col0);
  assign cols2 = {colgen(gidx2 + 1, row0, col0), colgen(gidx2, row0, col0)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream back-pressure
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      2'd0:    out_ready = 1'b1;
      2'd1:    out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard pop on transfer; hold-stability check while stalled
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (held_vld) chk("hold", 32'(hash), 32'(held));
      if (out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("hash", 32'(hash), 32'(sb.pop_front()));
        held_vld = 0;
      end else begin
        held = hash;
        held_vld = 1;
      end
    end else begin
      held_vld = 0;
    end
  end

  // Drive nb beats of d on the STRIDE=1 instance, waiting for in_ready first
  task automatic send1(input logic [7:0] d, input int nb, input bit push, input logic [L-1:0] exp);
    for (int b = 0; b < nb; b++) begin
      int guard;
      in_valid = 1'b1;
      in_data  = d[b];
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      if (b == 0 && push) sb.push_back(exp);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (nb == int'(N)) exp_blk++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef TOEPLITZ_MAC_STATS_EN
    chk({tag, "_blk"}, blk_cnt, 32'(exp_blk));
    chk({tag, "_abort"}, abort_cnt, 32'(exp_abort));
`else
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(out_valid ? 1'b0 : 1'b1));
`endif
  endtask

  initial begin
    logic [7:0]   d;
    logic [L-1:0] e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hash", 32'(hash), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_gen_reset", 32'(gen_reset), 32'd1);
    chk("rst_out_valid2", 32'(out_valid2), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // STRIDE=2: all-ones data gives XOR of all 8 columns after 4 beats
    row0 = 8'hA6;
    col0 = 4'b1011;
    d = 8'hFF;
    e = '0;
    for (int j = 0; j < int'(N); j++) e = e ^ colgen(j, row0, col0);
    for (int b = 0; b < 4; b++) begin
      chk("s2_in_ready", 32'(in_ready2), 32'd1);
      chk("s2_early_valid", 32'(out_valid2), 32'd0);
      in_valid2 = 1'b1;
      in_data2  = d[2*b +: 2];
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    chk("s2_out_valid", 32'(out_valid2), 32'd1);
    chk("s2_hash", 32'(hash2), 32'(e));
    @(posedge clk); #1;
    chk("s2_release", 32'(out_valid2), 32'd0);
`ifdef TOEPLITZ_MAC_STATS_EN
    chk("s2_blk", blk_cnt2, 32'd1);
    chk("s2_abort", abort_cnt2, 32'd0);
`endif

    // All-zero data and bit-0-only data
    row0 = 8'h00;
    col0 = 4'b1011;
    send1(8'h00, 8, 1'b1, 4'b0000);
    chk("lat_zero", 32'(out_valid), 32'd1);
    send1(8'h01, 8, 1'b1, 4'b1011);
    chk("lat_bit0", 32'(out_valid), 32'd1);
    drain();

    // Random blocks with random matrices and stalled downstream
    rdy_mode = 2'd1;
    for (int n = 0; n < 200; n++) begin
      row0 = 8'($urandom);
      col0 = 4'($urandom);
      d    = 8'($urandom);
      send1(d, 8, 1'b1, model_hash(d, row0, col0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rdy_mode = 2'd0;
    @(posedge clk); #1;

    // Abort after 3 beats, then a full block must still be correct
    row0 = 8'h5C;
    col0 = 4'b0110;
    send1(8'hE7, 3, 1'b0, '0);
    @(posedge clk); #1;
    exp_abort++;
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    send1(8'h9D, 8, 1'b1, model_hash(8'h9D, row0, col0));
    drain();
    check_stats("stats_pre_reset");

    // Reset in RUN at beat 5
    send1(8'h3C, 5, 1'b0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_blk = 0;
    exp_abort = 0;
    chk("rrun_out_valid", 32'(out_valid), 32'd0);
    chk("rrun_hash", 32'(hash), 32'd0);
    chk("rrun_in_ready", 32'(in_ready), 32'd1);
    send1(8'hB2, 8, 1'b1, model_hash(8'hB2, row0, col0));
    drain();

    // Reset in DONE drops the pending hash
    rdy_mode = 2'd2;
    @(posedge clk); #1;
    send1(8'h71, 8, 1'b0, '0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_gen_reset", 32'(gen_reset), 32'd1);
    chk("done_held_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_mode = 2'd0;
    exp_blk = 0;
    exp_abort = 0;
    chk("rdone_out_valid", 32'(out_valid), 32'd0);
    chk("rdone_hash", 32'(hash), 32'd0);
    send1(8'h4E, 8, 1'b1, model_hash(8'h4E, row0, col0));
    drain();
    @(posedge clk); #1;
    check_stats("stats_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
